// File: rtl/video_mode_ctrl.sv
// Mode controller for the HDMI TX timing generator: holds the timing-set ROM and
// sequences frame-aligned mode switches with the generator held in reset.
module video_mode_ctrl #(
    parameter logic [1:0] DEFAULT_MODE  = 2'd0,
    parameter int         HOLD_CYCLES   = 16,
    parameter int         FRAME_TIMEOUT = 2_000_000,
    parameter int         TIMEOUT_W     = 21
) (
    input  logic        pixel_clock,
    input  logic        reset_n,
    input  logic [1:0]  mode_sel,
    input  logic        mode_req,
    input  logic        v_sync,
    output logic        mode_ack,
    output logic        mode_err,
    output logic        busy,
    output logic        mode_ready,
    output logic [1:0]  current_mode,
    output logic        tg_reset_n,
    output logic [11:0] h_sync_length,
    output logic [11:0] h_total_pixels,
    output logic [11:0] h_start,
    output logic [11:0] h_end,
    output logic [11:0] v_sync_length,
    output logic [11:0] v_total_pixels,
    output logic [11:0] v_start,
    output logic [11:0] v_end,
    output logic [11:0] v_back_porch,
    output logic [1:0]  dbg_state
);
    localparam int HOLD_W = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0]    HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [TIMEOUT_W-1:0] TO_LAST   = TIMEOUT_W'(FRAME_TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    typedef struct packed {
        logic [11:0] h_total;
        logic [11:0] h_sync;
        logic [11:0] h_start;
        logic [11:0] h_end;
        logic [11:0] v_total;
        logic [11:0] v_sync;
        logic [11:0] v_start;
        logic [11:0] v_end;
        logic [11:0] v_bp;
    } timing_t;

    // Totals are stored as last count (total - 1); mode 3 is never loaded.
    function automatic timing_t rom_lookup(input logic [1:0] m);
        timing_t t;
        case (m)
            2'd1:    t = '{12'd1055, 12'd128, 12'd216, 12'd1016,
                           12'd627,  12'd4,   12'd27,  12'd627,  12'd23};
            2'd2:    t = '{12'd1649, 12'd40,  12'd260, 12'd1540,
                           12'd749,  12'd5,   12'd25,  12'd745,  12'd20};
            default: t = '{12'd799,  12'd96,  12'd144, 12'd784,
                           12'd524,  12'd2,   12'd35,  12'd515,  12'd33};
        endcase
        return t;
    endfunction

    state_t                 state_q, state_d;
    logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;
    logic [TIMEOUT_W-1:0]   to_cnt_q, to_cnt_d;
    logic [1:0]             pend_mode_q, pend_mode_d;
    logic [1:0]             cur_mode_q, cur_mode_d;
    timing_t                timing_q, timing_d;
    logic                   v_sync_d_q;
    logic                   boot_q, boot_d;
    logic                   tg_rst_n_q, tg_rst_n_d;
    logic                   busy_q, busy_d;
    logic                   ready_q, ready_d;
    logic                   ack_q, ack_d;
    logic                   err_q, err_d;

    logic frame_edge;
    logic to_done;
    logic hold_done;
    logic switch_req;

    assign frame_edge = v_sync_d_q && !v_sync;
    assign to_done    = (to_cnt_q == TO_LAST);
    assign hold_done  = (hold_cnt_q == HOLD_LAST);
    assign switch_req = mode_req && (mode_sel != 2'd3) && (mode_sel != cur_mode_q);

    always_ff @(posedge pixel_clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_HOLD;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:  if (switch_req) state_d = ST_WAIT;
            ST_WAIT: if (frame_edge || to_done) state_d = ST_HOLD;
            ST_HOLD: if (hold_done) state_d = ST_RUN;
            default: state_d = ST_HOLD;
        endcase
    end

    always_comb begin
        hold_cnt_d  = hold_cnt_q;
        to_cnt_d    = to_cnt_q;
        pend_mode_d = pend_mode_q;
        cur_mode_d  = cur_mode_q;
        timing_d    = timing_q;
        boot_d      = boot_q;
        ack_d       = 1'b0;
        err_d       = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (mode_req) begin
                    if (mode_sel == 2'd3) begin
                        err_d = 1'b1;
                    end else if (mode_sel == cur_mode_q) begin
                        ack_d = 1'b1;
                    end else begin
                        pend_mode_d = mode_sel;
                        to_cnt_d    = '0;
                    end
                end
            end
            ST_WAIT: begin
                // The only place the timing set changes outside of reset.
                if (frame_edge || to_done) begin
                    timing_d   = rom_lookup(pend_mode_q);
                    cur_mode_d = pend_mode_q;
                    hold_cnt_d = '0;
                end else if (to_cnt_q != '1) begin
                    to_cnt_d = to_cnt_q + TIMEOUT_W'(1);
                end
            end
            ST_HOLD: begin
                if (hold_done) begin
                    ack_d  = !boot_q;
                    boot_d = 1'b0;
                end else if (hold_cnt_q != '1) begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            default: ;
        endcase
        tg_rst_n_d = (state_d != ST_HOLD);
        busy_d     = (state_d != ST_RUN);
        ready_d    = (state_d == ST_RUN);
    end

    always_ff @(posedge pixel_clock or negedge reset_n) begin
        if (!reset_n) begin
            hold_cnt_q  <= '0;
            to_cnt_q    <= '0;
            pend_mode_q <= DEFAULT_MODE;
            cur_mode_q  <= DEFAULT_MODE;
            timing_q    <= rom_lookup(DEFAULT_MODE);
            v_sync_d_q  <= 1'b1;
            boot_q      <= 1'b1;
            tg_rst_n_q  <= 1'b0;
            busy_q      <= 1'b1;
            ready_q     <= 1'b0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            hold_cnt_q  <= hold_cnt_d;
            to_cnt_q    <= to_cnt_d;
            pend_mode_q <= pend_mode_d;
            cur_mode_q  <= cur_mode_d;
            timing_q    <= timing_d;
            v_sync_d_q  <= v_sync;
            boot_q      <= boot_d;
            tg_rst_n_q  <= tg_rst_n_d;
            busy_q      <= busy_d;
            ready_q     <= ready_d;
            ack_q       <= ack_d;
            err_q       <= err_d;
        end
    end

    assign mode_ack       = ack_q;
    assign mode_err       = err_q;
    assign busy           = busy_q;
    assign mode_ready     = ready_q;
    assign current_mode   = cur_mode_q;
    assign tg_reset_n     = tg_rst_n_q;
    assign h_total_pixels = timing_q.h_total;
    assign h_sync_length  = timing_q.h_sync;
    assign h_start        = timing_q.h_start;
    assign h_end          = timing_q.h_end;
    assign v_total_pixels = timing_q.v_total;
    assign v_sync_length  = timing_q.v_sync;
    assign v_start        = timing_q.v_start;
    assign v_end          = timing_q.v_end;
    assign v_back_porch   = timing_q.v_bp;
    assign dbg_state      = state_q;
endmodule

// File: tb/tb_video_mode_ctrl.sv
// Randomized bench for video_mode_ctrl: a remaining-cycles model of the mode switch
// is compared against the DUT every cycle, with literal pins on key timing values.
module tb_video_mode_ctrl;
    localparam int HOLD = 16;
    localparam int FT   = 300;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  mode_sel = 2'd0;
    logic        mode_req = 1'b0;
    logic        v_sync = 1'b1;
    logic        mode_ack, mode_err, busy, mode_ready, tg_reset_n;
    logic [1:0]  current_mode, dbg_state;
    logic [11:0] h_sync_length, h_total_pixels, h_start, h_end;
    logic [11:0] v_sync_length, v_total_pixels, v_start, v_end, v_back_porch;

    video_mode_ctrl #(
        .DEFAULT_MODE (2'd0),
        .HOLD_CYCLES  (HOLD),
        .FRAME_TIMEOUT(FT),
        .TIMEOUT_W    (21)
    ) dut (
        .pixel_clock   (clk),
        .reset_n       (rst_n),
        .mode_sel      (mode_sel),
        .mode_req      (mode_req),
        .v_sync        (v_sync),
        .mode_ack      (mode_ack),
        .mode_err      (mode_err),
        .busy          (busy),
        .mode_ready    (mode_ready),
        .current_mode  (current_mode),
        .tg_reset_n    (tg_reset_n),
        .h_sync_length (h_sync_length),
        .h_total_pixels(h_total_pixels),
        .h_start       (h_start),
        .h_end         (h_end),
        .v_sync_length (v_sync_length),
        .v_total_pixels(v_total_pixels),
        .v_start       (v_start),
        .v_end         (v_end),
        .v_back_porch  (v_back_porch),
        .dbg_state     (dbg_state)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [3:0] exp_q[$];

    int h_tot_t[3] = '{799, 1055, 1649};
    int h_syn_t[3] = '{96, 128, 40};
    int h_sta_t[3] = '{144, 216, 260};
    int h_end_t[3] = '{784, 1016, 1540};
    int v_tot_t[3] = '{524, 627, 749};
    int v_syn_t[3] = '{2, 4, 5};
    int v_sta_t[3] = '{35, 27, 25};
    int v_end_t[3] = '{515, 627, 745};
    int v_bp_t[3]  = '{33, 23, 20};

    // Model: the switch is described by cycles left to wait / to hold.
    int m_cur, m_pend, m_hold_left, m_wait_cnt;
    bit m_waiting, m_boot, m_ack, m_err, m_prev_vs;

    bit vs_run = 1'b1;
    int ack_cnt = 0, err_cnt = 0, tg_fall_cnt = 0, low_run = 0, last_low_run = 0;
    logic tg_prev = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [107:0] exp_timing(input int m);
        return {12'(h_tot_t[m]), 12'(h_syn_t[m]), 12'(h_sta_t[m]), 12'(h_end_t[m]),
                12'(v_tot_t[m]), 12'(v_syn_t[m]), 12'(v_sta_t[m]), 12'(v_end_t[m]),
                12'(v_bp_t[m])};
    endfunction

    task automatic model_reset();
        m_cur = 0;
        m_pend = 0;
        m_hold_left = HOLD;
        m_wait_cnt = 0;
        m_waiting = 1'b0;
        m_boot = 1'b1;
        m_ack = 1'b0;
        m_err = 1'b0;
        m_prev_vs = 1'b1;
        exp_q.delete();
    endtask

    task automatic model_step();
        m_ack = 1'b0;
        m_err = 1'b0;
        if (m_hold_left > 0) begin
            m_hold_left--;
            if (m_hold_left == 0) begin
                m_ack = !m_boot;
                m_boot = 1'b0;
            end
        end else if (m_waiting) begin
            if ((m_prev_vs && !v_sync) || m_wait_cnt == FT - 1) begin
                m_waiting = 1'b0;
                m_cur = m_pend;
                m_hold_left = HOLD;
            end else begin
                m_wait_cnt++;
            end
        end else if (mode_req) begin
            if (mode_sel == 2'd3) m_err = 1'b1;
            else if (int'(mode_sel) == m_cur) m_ack = 1'b1;
            else begin
                m_waiting = 1'b1;
                m_pend = int'(mode_sel);
                m_wait_cnt = 0;
            end
        end
        m_prev_vs = v_sync;
        if (m_ack || m_err) exp_q.push_back({m_ack, m_err, 2'(m_cur)});
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    // Compare process plus pulse/low-run monitors, all on the falling edge.
    initial begin
        logic [3:0] exp_pulse;
        logic       busy_e;
        forever begin
            @(negedge clk);
            busy_e = m_waiting || (m_hold_left > 0);
            check("ctrl", {tg_reset_n, busy, mode_ready, mode_ack, mode_err},
                  {m_hold_left == 0, busy_e, !busy_e, m_ack, m_err});
            check("current_mode", current_mode, m_cur);
            check("timing", {h_total_pixels, h_sync_length, h_start, h_end,
                             v_total_pixels, v_sync_length, v_start, v_end, v_back_porch},
                  exp_timing(m_cur));
            if (mode_ack || mode_err) begin
                exp_pulse = (exp_q.size() != 0) ? exp_q.pop_front() : 4'h0;
                check("pulse", {mode_ack, mode_err, current_mode}, exp_pulse);
            end
            if (mode_ack) ack_cnt++;
            if (mode_err) err_cnt++;
            if (tg_prev && !tg_reset_n) tg_fall_cnt++;
            if (!tg_reset_n) low_run++;
            else if (!tg_prev) begin
                last_low_run = low_run;
                low_run = 0;
            end
            tg_prev = tg_reset_n;
        end
    end

    // v_sync source: random frame length, three-cycle low pulse at frame end.
    initial begin
        int ph;
        int len;
        ph = 0;
        len = 50;
        forever begin
            @(negedge clk);
            #1;
            if (!vs_run) begin
                v_sync = 1'b1;
                ph = 0;
            end else begin
                ph++;
                if (ph >= len) begin
                    ph = 0;
                    len = $urandom_range(30, 80);
                end
                v_sync = (ph >= len - 3) ? 1'b0 : 1'b1;
            end
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
        #1;
    endtask

    task automatic do_req(input logic [1:0] sel);
        tick(1);
        mode_sel = sel;
        mode_req = 1'b1;
        tick(1);
        mode_req = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name, output int k);
        k = 0;
        while (busy !== 1'b0 && k < budget) begin
            tick(1);
            k++;
        end
        if (k >= budget) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: busy still %b after %0d cycles", name, busy, k);
        end
    endtask

    initial begin
        #500_000;
        n_cmp++;
        n_bad++;
        $display("FAIL global_timeout: simulation still running at t=%0t", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        int k, a0, e0, f0;
        logic [1:0] sel;

        // 1: boot hold, default timing, no ack
        tick(3);
        rst_n = 1'b1;
        wait_idle(100, "t1_boot", k);
        check("t1_h_total", h_total_pixels, 12'd799);
        check("t1_h_end", h_end, 12'd784);
        check("t1_v_total", v_total_pixels, 12'd524);
        check("t1_v_start", v_start, 12'd35);
        check("t1_ready", {mode_ready, busy, tg_reset_n}, 3'b101);
        check("t1_no_ack", ack_cnt, 0);

        // 2: switch to mode 2 on the next frame edge
        tick($urandom_range(5, 20));
        a0 = ack_cnt;
        do_req(2'd2);
        check("t2_busy", busy, 1'b1);
        wait_idle(200, "t2_switch", k);
        check("t2_h_total", h_total_pixels, 12'd1649);
        check("t2_h_start", h_start, 12'd260);
        check("t2_v_end", v_end, 12'd745);
        check("t2_mode", current_mode, 2'd2);
        check("t2_low_run", last_low_run, HOLD);
        check("t2_acks", ack_cnt, a0 + 1);

        // 3: invalid mode rejected
        e0 = err_cnt;
        f0 = tg_fall_cnt;
        do_req(2'd3);
        check("t3_err", err_cnt, e0 + 1);
        check("t3_state", {busy, tg_reset_n}, 2'b01);
        check("t3_h_total", h_total_pixels, 12'd1649);

        // 4: same mode acknowledged without a hold
        a0 = ack_cnt;
        do_req(2'd2);
        tick(3);
        check("t4_ack", ack_cnt, a0 + 1);
        check("t4_no_fall", tg_fall_cnt, f0);

        // 5: no frame edge, timeout forces the switch
        vs_run = 1'b0;
        tick(3);
        do_req(2'd1);
        wait_idle(FT + HOLD + 50, "t5_timeout", k);
        check("t5_busy_cycles", k, FT + HOLD);
        check("t5_h_total", h_total_pixels, 12'd1055);
        check("t5_v_total", v_total_pixels, 12'd627);

        // 6: second request ignored, reset mid-hold
        vs_run = 1'b1;
        a0 = ack_cnt;
        do_req(2'd0);
        do_req(2'd2);
        k = 0;
        while (tg_reset_n !== 1'b0 && k < 200) begin
            tick(1);
            k++;
        end
        if (k >= 200) begin
            n_cmp++;
            n_bad++;
            $display("FAIL t6_hold_entry: tg_reset_n still %b", tg_reset_n);
        end
        tick(5);
        rst_n = 1'b0;
        tick(1);
        check("t6_rst_ctrl", {busy, tg_reset_n, mode_ready}, 3'b100);
        check("t6_rst_h_total", h_total_pixels, 12'd799);
        check("t6_rst_mode", current_mode, 2'd0);
        tick(2);
        rst_n = 1'b1;
        wait_idle(100, "t6_reboot", k);
        check("t6_no_ack", ack_cnt, a0);

        // Random requests, including many while busy
        for (int i = 0; i < 40; i++) begin
            sel = 2'($urandom_range(0, 3));
            tick($urandom_range(1, 30));
            do_req(sel);
        end
        wait_idle(FT + HOLD + 50, "rand_drain", k);
        tick(3);
        check("exp_q_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
